// File: rtl/act_lut_interp_pkg.sv
// Shared widths and arithmetic helpers for the activation LUT interpolators
// (tanh here; the sigmoid variant reuses the same package and MAC).
package act_lut_interp_pkg;

    localparam int ACT_DATA_W = 8;
    localparam int ACT_ADDR_W = 4;
    localparam int ACT_FRAC_W = ACT_DATA_W - ACT_ADDR_W;

    function automatic int round_const(input int frac_w, input int round);
        return (round != 0) ? (1 << (frac_w - 1)) : 0;
    endfunction

    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/act_lut_interp_if.sv
// Valid/ready stream bundle: x in from the MAC accumulator, y out to the next layer.
interface act_lut_interp_if
    import act_lut_interp_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] y;

    modport master (
        output in_valid, output x, input in_ready,
        input out_valid, input y, output out_ready
    );

    modport slave (
        input in_valid, input x, output in_ready,
        output out_valid, output y, input out_ready
    );

endinterface

// File: rtl/act_interp_mac.sv
// Combinational interpolation datapath: (next-base)*frac, then base + rounded
// shift of the registered product, saturated back to DATA_W.
module act_interp_mac
    import act_lut_interp_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W,
    parameter int FRAC_W = ACT_FRAC_W,
    parameter int ROUND  = 1
) (
    input  logic signed [DATA_W-1:0]        i_base,
    input  logic signed [DATA_W-1:0]        i_next,
    input  logic        [FRAC_W-1:0]        i_frac,
    output logic signed [DATA_W+FRAC_W+1:0] o_prod,
    input  logic signed [DATA_W+FRAC_W+1:0] i_prod,
    input  logic signed [DATA_W-1:0]        i_acc_base,
    output logic signed [DATA_W-1:0]        o_sum
);

    localparam int PW = DATA_W + FRAC_W + 2;
    localparam logic signed [PW:0] RC = (PW+1)'(round_const(FRAC_W, ROUND));

    logic signed [DATA_W:0] w_diff;
    logic signed [FRAC_W:0] w_frac_s;
    logic signed [PW:0]     w_rounded;
    logic signed [PW:0]     w_shifted;
    logic signed [PW+1:0]   w_sum;

    // Fraction is unsigned, so it gets a zero sign bit before the signed multiply.
    assign w_diff    = (DATA_W+1)'(i_next) - (DATA_W+1)'(i_base);
    assign w_frac_s  = {1'b0, i_frac};
    assign o_prod    = PW'(w_diff) * PW'(w_frac_s);

    assign w_rounded = (PW+1)'(i_prod) + RC;
    assign w_shifted = w_rounded >>> FRAC_W;
    assign w_sum     = (PW+2)'(i_acc_base) + (PW+2)'(w_shifted);
    assign o_sum     = DATA_W'(sat_signed(32'(w_sum), DATA_W));

endmodule

// File: rtl/act_lut_interp.sv
// Pipelined piecewise-linear tanh interpolator sitting behind an external LUT.
// Stages: S1 holds x (drives LUT address), S2 holds base/next/frac, S3 holds product, then y.
module act_lut_interp
    import act_lut_interp_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W,
    parameter int ADDR_W = ACT_ADDR_W,
    parameter int FRAC_W = DATA_W - ADDR_W,
    parameter int ROUND  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    act_lut_interp_if.slave          bus,
    output logic        [ADDR_W-1:0] lut_address,
    input  logic signed [DATA_W-1:0] lut_base,
    input  logic signed [DATA_W-1:0] lut_next
);

    localparam int PW = DATA_W + FRAC_W + 2;

    logic                     w_stall;
    logic signed [PW-1:0]     w_prod;
    logic signed [DATA_W-1:0] w_sum;

    logic                     r_vld_p1;
    logic                     r_vld_p2;
    logic                     r_vld_p3;
    logic                     r_out_vld;
    logic signed [DATA_W-1:0] r_x_p1;
    logic signed [DATA_W-1:0] r_base_p2;
    logic signed [DATA_W-1:0] r_next_p2;
    logic        [FRAC_W-1:0] r_frac_p2;
    logic signed [PW-1:0]     r_prod_p3;
    logic signed [DATA_W-1:0] r_base_p3;
    logic signed [DATA_W-1:0] r_y;

    // One global stall: every stage holds together, so bubbles stay in place.
    assign w_stall       = r_out_vld & ~bus.out_ready;
    assign bus.in_ready  = ~w_stall;
    assign bus.out_valid = r_out_vld;
    assign bus.y         = r_y;
    assign lut_address   = r_x_p1[DATA_W-1 -: ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_vld_p3  <= 1'b0;
            r_out_vld <= 1'b0;
            r_x_p1    <= '0;
            r_y       <= '0;
        end else if (!w_stall) begin
            r_vld_p1  <= bus.in_valid;
            r_vld_p2  <= r_vld_p1;
            r_vld_p3  <= r_vld_p2;
            r_out_vld <= r_vld_p3;
            if (bus.in_valid) r_x_p1 <= bus.x;
            // y only moves on a real item so it keeps its last value across bubbles.
            if (r_vld_p3) r_y <= w_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_base_p2 <= lut_base;
            r_next_p2 <= lut_next;
            r_frac_p2 <= r_x_p1[FRAC_W-1:0];
            r_prod_p3 <= w_prod;
            r_base_p3 <= r_base_p2;
        end
    end

    act_interp_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ROUND  (ROUND)
    ) u_mac (
        .i_base     (r_base_p2),
        .i_next     (r_next_p2),
        .i_frac     (r_frac_p2),
        .o_prod     (w_prod),
        .i_prod     (r_prod_p3),
        .i_acc_base (r_base_p3),
        .o_sum      (w_sum)
    );

endmodule

// File: tb/tb_act_lut_interp.sv
// Scoreboard bench: a ROUND=1 and a ROUND=0 instance see identical stimulus and
// share one LUT model; expectations are queued at accept and popped by a monitor.
module tb_act_lut_interp;
    import act_lut_interp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    act_lut_interp_if bus1 ();
    act_lut_interp_if bus0 ();

    logic        [3:0] a1, a0;
    logic signed [7:0] b1, n1, b0, n0;
    logic signed [7:0] tbl [16];

    int checks = 0;
    int errors = 0;
    int q1[$];
    int q0[$];
    int e1, e0;

    act_lut_interp #(.ROUND(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave),
        .lut_address(a1), .lut_base(b1), .lut_next(n1)
    );

    act_lut_interp #(.ROUND(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave),
        .lut_address(a0), .lut_base(b0), .lut_next(n0)
    );

    // LUT model: address 7 holds (next = base), address 15 wraps to entry 0.
    function automatic logic [3:0] nxt(input logic [3:0] a);
        return (a == 4'd7) ? a : a + 4'd1;
    endfunction

    always_comb begin
        b1 = tbl[a1];
        n1 = tbl[nxt(a1)];
        b0 = tbl[a0];
        n0 = tbl[nxt(a0)];
    end

    // Identity table: every segment has slope 16, so y = x except the held top segment.
    function automatic int ident_y(input int xv);
        logic [7:0] b;
        b = 8'(xv);
        if (b[7:4] == 4'd7) return 112;
        return int'($signed(b));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus1.out_valid && bus1.out_ready) begin
                if (q1.size() == 0) check("r1_spurious_output", int'(bus1.y), -999);
                else begin
                    e1 = q1.pop_front();
                    check("r1_y", int'(bus1.y), e1);
                end
            end
            if (bus0.out_valid && bus0.out_ready) begin
                if (q0.size() == 0) check("r0_spurious_output", int'(bus0.y), -999);
                else begin
                    e0 = q0.pop_front();
                    check("r0_y", int'(bus0.y), e0);
                end
            end
        end
    end

    task automatic set_in(input logic v, input logic [7:0] xv);
        bus1.in_valid = v;
        bus1.x        = xv;
        bus0.in_valid = v;
        bus0.x        = xv;
    endtask

    task automatic set_ready(input logic r);
        bus1.out_ready = r;
        bus0.out_ready = r;
    endtask

    task automatic send(input logic [7:0] xv, input int ex1, input int ex0,
                        input bit expect_out, output int tries);
        bit done;
        set_in(1'b1, xv);
        tries = 0;
        done  = 1'b0;
        while (!done && tries < 100) begin
            @(negedge clk);
            done = bus1.in_ready && bus0.in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!done) check("send_timeout", 0, 1);
        else if (expect_out) begin
            q1.push_back(ex1);
            q0.push_back(ex0);
        end
    endtask

    task automatic drain();
        int n;
        set_in(1'b0, 8'h00);
        n = 0;
        while ((q1.size() != 0 || q0.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_left", q1.size() + q0.size(), 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, int'(bus1.out_valid) + int'(bus0.out_valid), 0);
        check({tag, "_y1"}, int'(bus1.y), 0);
        check({tag, "_y0"}, int'(bus0.y), 0);
        check({tag, "_in_ready"}, int'(bus1.in_ready) + int'(bus0.in_ready), 2);
        check({tag, "_lut_address"}, int'(a1) + int'(a0), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired actual running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        int run;
        for (int k = 0; k < 16; k++) tbl[k] = 8'(16 * k);
        rst = 1'b1;
        set_in(1'b0, 8'h00);
        set_ready(1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("reset");

        // Single item: first output 4 cycles after accept.
        send(8'h18, 24, 24, 1'b1, t);
        set_in(1'b0, 8'h00);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus1.out_valid && n < 20);
        check("latency", n, 4);
        drain();

        send(8'h7F, 112, 112, 1'b1, t);
        send(8'hFF, -1, -1, 1'b1, t);
        send(8'h80, -128, -128, 1'b1, t);
        send(8'h10, 16, 16, 1'b1, t);
        drain();

        // Full-rate stream while a second process checks contiguity of outputs.
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    send(8'(i), ident_y(i), ident_y(i), 1'b1, t);
                    check("stream_in_ready", t, 1);
                end
                set_in(1'b0, 8'h00);
            end
            begin
                int m;
                m   = 0;
                run = 0;
                while (!bus1.out_valid && m < 50) begin
                    @(negedge clk);
                    m++;
                end
                repeat (256) begin
                    if (bus1.out_valid && bus0.out_valid) run++;
                    @(negedge clk);
                end
                check("stream_contiguous", run, 256);
            end
        join
        drain();

        // Back-pressure with two items in flight and a third waiting at the input.
        set_ready(1'b0);
        send(8'h18, 24, 24, 1'b1, t);
        send(8'h25, 37, 37, 1'b1, t);
        set_in(1'b0, 8'h00);
        n = 0;
        while (!bus1.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        set_in(1'b1, 8'h40);
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", int'(bus1.in_ready) + int'(bus0.in_ready), 0);
            check("stall_y1_hold", int'(bus1.y), 24);
            check("stall_y0_hold", int'(bus0.y), 24);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        set_ready(1'b1);
        send(8'h40, 64, 64, 1'b1, t);
        check("release_accept_tries", t, 1);
        drain();

        // Reset with three items in flight: none of them may ever appear.
        send(8'h30, 0, 0, 1'b0, t);
        send(8'h31, 0, 0, 1'b0, t);
        send(8'h32, 0, 0, 1'b0, t);
        set_in(1'b0, 8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("midreset");
        repeat (10) @(posedge clk);
        #1;
        send(8'h18, 24, 24, 1'b1, t);
        drain();

        // Rounding: entry 1 = 17 makes ROUND=1 and ROUND=0 differ at larger fractions.
        send(8'h01, 1, 1, 1'b1, t);
        drain();
        tbl[1] = 8'sd17;
        send(8'h01, 1, 1, 1'b1, t);
        send(8'h08, 9, 8, 1'b1, t);
        send(8'h0F, 16, 15, 1'b1, t);
        send(8'h00, 0, 0, 1'b1, t);
        drain();

        // Extreme segments near the saturation limits.
        tbl[1] = 8'sd120;
        tbl[2] = 8'sd127;
        send(8'h1F, 127, 126, 1'b1, t);
        send(8'h10, 120, 120, 1'b1, t);
        drain();
        tbl[2] = -8'sd128;
        send(8'h1F, -112, -113, 1'b1, t);
        send(8'h18, -4, -4, 1'b1, t);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
